comm_sequencer: RTL and testbench

//  Top-level transfer controller for the UART comm unit (op/start/busy/rx_complete/tx_complete).

---
 rtl/comm_sequencer_if.sv | 50 +++++
 rtl/comm_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_comm_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/comm_sequencer_if.sv
// Bus bundle between the comm sequencer and its neighbours: comm UART unit,
// A/B vector buffers, SpMM multiplier and result buffer.
//
// Handshake semantics: every start/strobe/complete signal is a one-cycle
// pulse with no ready; the receiver must act on it in the cycle it is high.
// Data is valid in the same cycle as its pulse (comm_rx_data with
// comm_rx_complete, vec_addr/vec_data with a_we/b_we), except res_data, which
// is valid the cycle after res_rd.
interface comm_sequencer_if #(
    parameter int N     = 4,
    parameter int W     = 16,
    parameter int PKT_W = 8 + 2 * W * N
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    logic             go;
    logic             comm_op;
    logic             comm_start;
    logic             comm_busy;
    logic             comm_rx_complete;
    logic [PKT_W-1:0] comm_rx_data;
    logic             comm_tx_complete;
    logic [PKT_W-1:0] comm_tx_data;
    logic             a_we;
    logic             b_we;
    logic [AW-1:0]    vec_addr;
    logic [PKT_W-1:0] vec_data;
    logic             mm_start;
    logic             mm_done;
    logic             res_rd;
    logic [AW-1:0]    res_addr;
    logic [PKT_W-1:0] res_data;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        input  go, comm_busy, comm_rx_complete, comm_rx_data, comm_tx_complete,
               mm_done, res_data,
        output comm_op, comm_start, comm_tx_data, a_we, b_we, vec_addr, vec_data,
               mm_start, res_rd, res_addr, busy, done, err
    );

    modport slave (
        output go, comm_busy, comm_rx_complete, comm_rx_data, comm_tx_complete,
               mm_done, res_data,
        input  comm_op, comm_start, comm_tx_data, a_we, b_we, vec_addr, vec_data,
               mm_start, res_rd, res_addr, busy, done, err
    );
endinterface

// File: rtl/comm_sequencer.sv
// Job sequencer for the UART comm unit: loads N A-rows and N B-columns,
// kicks the SpMM multiplier, then reads and transmits N result rows.
// o_dbg_state exposes the FSM state encoding for observation.
module comm_sequencer #(
    parameter int N       = 4,
    parameter int W       = 16,
    parameter int PKT_W   = 8 + 2 * W * N,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    comm_sequencer_if.master bus,
    output logic [3:0]       o_dbg_state
);
    localparam int            AW        = (N > 1) ? $clog2(N) : 1;
    localparam int            TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [AW-1:0] LAST_IDX  = AW'(N - 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);
    // Largest legal size byte: one packet carries at most N values of W bits.
    localparam logic [7:0]    MAX_SIZE  = 8'(N * W / 8);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LD_REQ  = 4'd1,
        S_LD_WAIT = 4'd2,
        S_LD_WR   = 4'd3,
        S_MM_GO   = 4'd4,
        S_MM_WAIT = 4'd5,
        S_RD_REQ  = 4'd6,
        S_RD_CAP  = 4'd7,
        S_TX_REQ  = 4'd8,
        S_TX_WAIT = 4'd9,
        S_FIN     = 4'd10
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_idx;
    logic             r_phase_b;
    logic [TW-1:0]    r_timer;
    logic             r_op;
    logic             r_err;
    logic [PKT_W-1:0] r_vec_data;
    logic [PKT_W-1:0] r_tx_data;

    state_t           w_next;
    logic [AW-1:0]    w_idx_next;
    logic             w_phase_b_next;
    logic             w_op;
    logic             w_err_set;
    logic             w_err_clr;
    logic             w_count;
    logic             w_cap_rx;
    logic             w_cap_tx;
    logic             w_start;
    logic             w_a_we;
    logic             w_b_we;
    logic             w_mm_start;
    logic             w_res_rd;
    logic             w_done;

    // Next-state, index/phase updates and single-cycle strobes.
    always_comb begin
        w_next         = r_state;
        w_idx_next     = r_idx;
        w_phase_b_next = r_phase_b;
        w_op           = r_op;
        w_err_set      = 1'b0;
        w_err_clr      = 1'b0;
        w_count        = 1'b0;
        w_cap_rx       = 1'b0;
        w_cap_tx       = 1'b0;
        w_start        = 1'b0;
        w_a_we         = 1'b0;
        w_b_we         = 1'b0;
        w_mm_start     = 1'b0;
        w_res_rd       = 1'b0;
        w_done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.go) begin
                    w_next         = S_LD_REQ;
                    w_idx_next     = '0;
                    w_phase_b_next = 1'b0;
                    w_err_clr      = 1'b1;
                end
            end
            S_LD_REQ: begin
                w_count = 1'b1;
                // Direction switches only while comm is idle, together with start.
                if (!bus.comm_busy) begin
                    w_op    = 1'b0;
                    w_start = 1'b1;
                    w_next  = S_LD_WAIT;
                end
            end
            S_LD_WAIT: begin
                w_count = 1'b1;
                if (bus.comm_rx_complete) begin
                    w_cap_rx = 1'b1;
                    w_next   = S_LD_WR;
                    // Oversized packets are flagged but still stored.
                    if (bus.comm_rx_data[PKT_W-1 -: 8] > MAX_SIZE) begin
                        w_err_set = 1'b1;
                    end
                end
            end
            S_LD_WR: begin
                w_a_we = !r_phase_b;
                w_b_we = r_phase_b;
                if (r_idx != LAST_IDX) begin
                    w_idx_next = r_idx + AW'(1);
                    w_next     = S_LD_REQ;
                end else if (!r_phase_b) begin
                    w_phase_b_next = 1'b1;
                    w_idx_next     = '0;
                    w_next         = S_LD_REQ;
                end else begin
                    w_next = S_MM_GO;
                end
            end
            S_MM_GO: begin
                w_mm_start = 1'b1;
                w_next     = S_MM_WAIT;
            end
            S_MM_WAIT: begin
                w_count = 1'b1;
                if (bus.mm_done) begin
                    w_idx_next = '0;
                    w_next     = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                w_res_rd = 1'b1;
                w_next   = S_RD_CAP;
            end
            S_RD_CAP: begin
                w_cap_tx = 1'b1;
                w_next   = S_TX_REQ;
            end
            S_TX_REQ: begin
                w_count = 1'b1;
                if (!bus.comm_busy) begin
                    w_op    = 1'b1;
                    w_start = 1'b1;
                    w_next  = S_TX_WAIT;
                end
            end
            S_TX_WAIT: begin
                w_count = 1'b1;
                if (bus.comm_tx_complete) begin
                    if (r_idx != LAST_IDX) begin
                        w_idx_next = r_idx + AW'(1);
                        w_next     = S_RD_REQ;
                    end else begin
                        w_next = S_FIN;
                    end
                end
            end
            S_FIN: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // A stalled wait aborts the job; an event arriving on the last cycle wins.
        if (w_count && (w_next == r_state) && (r_timer == TIMER_MAX)) begin
            w_next    = S_IDLE;
            w_err_set = 1'b1;
        end
    end

    // State, index, sticky error and data capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_phase_b  <= 1'b0;
            r_op       <= 1'b0;
            r_err      <= 1'b0;
            r_vec_data <= '0;
            r_tx_data  <= '0;
        end else begin
            r_state   <= w_next;
            r_idx     <= w_idx_next;
            r_phase_b <= w_phase_b_next;
            r_op      <= w_op;
            if (w_err_clr) begin
                r_err <= 1'b0;
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_cap_rx) begin
                r_vec_data <= bus.comm_rx_data;
            end
            if (w_cap_tx) begin
                r_tx_data <= bus.res_data;
            end
        end
    end

    // Per-state wait timer: restarts on every state entry, counts in wait states.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else if (w_next != r_state) begin
            r_timer <= '0;
        end else if (w_count) begin
            r_timer <= r_timer + TW'(1);
        end
    end

    // Strobes are masked while rst is high so a mid-job reset emits no pulse.
    assign bus.comm_start   = w_start & ~rst;
    assign bus.comm_op      = w_op & ~rst;
    assign bus.a_we         = w_a_we & ~rst;
    assign bus.b_we         = w_b_we & ~rst;
    assign bus.mm_start     = w_mm_start & ~rst;
    assign bus.res_rd       = w_res_rd & ~rst;
    assign bus.done         = w_done & ~rst;
    assign bus.vec_addr     = r_idx;
    assign bus.res_addr     = r_idx;
    assign bus.vec_data     = r_vec_data;
    assign bus.comm_tx_data = r_tx_data;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.err          = r_err;
    assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_comm_sequencer.sv
// Directed bench for comm_sequencer: table of load packets, scoreboard of
// expected buffer writes, hand sequences for reset, busy gating, errors,
// timeout and stray events. TIMEOUT is shortened to 64 so the timeout path
// is reachable; the multiplier latency is therefore kept below it.
module tb_comm_sequencer;
    localparam int N       = 4;
    localparam int W       = 16;
    localparam int PKT_W   = 8 + 2 * W * N;
    localparam int AW      = 2;
    localparam int SB_W    = 2 + AW + PKT_W;
    localparam int CW      = 160;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic [PKT_W-1:0] pkt;
        logic             is_b;
        logic [AW-1:0]    addr;
    } ld_vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  dbg_state;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          st_cnt = 0;
    int          st_op_bad = 0;
    int          done_cnt = 0;
    logic        exp_op = 1'b0;
    logic [SB_W-1:0]  exp_q[$];
    ld_vec_t          ld_tab[2*N];
    logic [PKT_W-1:0] row_tab[N];

    comm_sequencer_if #(.N(N), .W(W), .PKT_W(PKT_W)) bus ();

    comm_sequencer #(.N(N), .W(W), .PKT_W(PKT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.master),
        .o_dbg_state (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic sig_sel(input int sel);
        case (sel)
            0:       return bus.comm_start;
            1:       return bus.mm_start;
            2:       return bus.res_rd;
            default: return bus.done;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns at the negedge where the selected strobe is high.
    task automatic wait_for(input int sel, input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (sig_sel(sel)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic pulse_go();
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
    endtask

    // Called at posedge+1 while the DUT sits in LD_WAIT.
    task automatic rx_packet(input int k, input bit bad);
        logic [PKT_W-1:0] pkt;
        pkt = ld_tab[k].pkt;
        if (bad) pkt[PKT_W-1 -: 8] = 8'd9;
        exp_q.push_back({!ld_tab[k].is_b, ld_tab[k].is_b, ld_tab[k].addr, pkt});
        tick();
        bus.comm_rx_data     = pkt;
        bus.comm_rx_complete = 1'b1;
        tick();
        bus.comm_rx_complete = 1'b0;
        bus.comm_rx_data     = '1;
    endtask

    task automatic load_pkt(input int k, input bit bad);
        wait_for(0, 100, "ld_start");
        tick();
        rx_packet(k, bad);
    endtask

    task automatic send_results(input int mm_delay);
        wait_for(1, 20, "mm_start");
        tick();
        repeat (mm_delay) tick();
        bus.mm_done = 1'b1;
        tick();
        bus.mm_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            wait_for(2, 20, "res_rd");
            check("res_addr", CW'(bus.res_addr), CW'(i));
            tick();
            bus.res_data = row_tab[i];
            tick();
            bus.res_data = '1;
            wait_for(0, 20, "tx_start");
            tick();
            bus.comm_busy = 1'b1;
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                check("tx_data_stable", CW'(bus.comm_tx_data), CW'(row_tab[i]));
                tick();
            end
            bus.comm_tx_complete = 1'b1;
            bus.comm_busy        = 1'b0;
            tick();
            bus.comm_tx_complete = 1'b0;
        end
        wait_for(3, 10, "done");
        check("busy_at_done", CW'(bus.busy), CW'(1));
        @(negedge clk);
        check("done_then_idle", CW'({bus.done, bus.busy}), CW'(0));
        tick();
    endtask

    // Scoreboard / monitor: buffer writes against expected queue, start and done counters.
    always @(negedge clk) begin
        if (bus.comm_start) begin
            st_cnt++;
            if (bus.comm_op !== exp_op) st_op_bad++;
        end
        if (bus.done) done_cnt++;
        if (bus.a_we || bus.b_we) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: a_we=%0b b_we=%0b addr=%0d", bus.a_we, bus.b_we, bus.vec_addr);
            end else begin
                check("buf_write", CW'({bus.a_we, bus.b_we, bus.vec_addr, bus.vec_data}), CW'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [PKT_W-1:0] base;
        int cnt;
        // Vector tables
        base = {8'd4, 64'h74FB7BFE_00000000, 64'h0000_0003_0000_0000};
        for (int k = 0; k < 2 * N; k++) begin
            ld_tab[k].pkt  = base | PKT_W'(k);
            ld_tab[k].is_b = (k >= N);
            ld_tab[k].addr = AW'(k % N);
        end
        row_tab[0] = {8'd8, {16{8'h00}}};
        row_tab[1] = {8'd8, {16{8'h01}}};
        row_tab[2] = {8'd8, {16{8'h02}}};
        row_tab[3] = {8'd8, {16{8'h03}}};

        bus.go = 1'b0; bus.comm_busy = 1'b0; bus.comm_rx_complete = 1'b0;
        bus.comm_rx_data = '1; bus.comm_tx_complete = 1'b0; bus.mm_done = 1'b0;
        bus.res_data = '1;

        // Power-on reset
        repeat (3) tick();
        @(negedge clk);
        check("por_ctrl", CW'({bus.busy, bus.done, bus.err, bus.comm_start, bus.comm_op, bus.a_we,
              bus.b_we, bus.mm_start, bus.res_rd, bus.vec_addr, bus.res_addr, dbg_state}), CW'(0));
        tick();
        rst = 1'b0;

        // Reset held 3 clk in the middle of LD_WAIT
        pulse_go();
        load_pkt(0, 1'b0);
        wait_for(0, 20, "ld_start");
        tick();
        rst = 1'b1;
        exp_q.delete();
        repeat (3) tick();
        @(negedge clk);
        check("rst_ctrl", CW'({bus.busy, bus.done, bus.err, bus.comm_start, bus.comm_op, bus.a_we,
              bus.b_we, bus.mm_start, bus.res_rd, bus.vec_addr, bus.res_addr, dbg_state}), CW'(0));
        check("rst_vec_data", CW'(bus.vec_data), CW'(0));
        check("rst_tx_data", CW'(bus.comm_tx_data), CW'(0));
        tick();
        rst = 1'b0;

        // Full job: loads with stray events on the first LD_WAIT, then compute/send
        st_cnt = 0; st_op_bad = 0; done_cnt = 0; exp_op = 1'b0;
        pulse_go();
        wait_for(0, 20, "ld_start");
        tick();
        bus.go = 1'b1; bus.mm_done = 1'b1; bus.comm_tx_complete = 1'b1;
        tick();
        bus.go = 1'b0; bus.mm_done = 1'b0; bus.comm_tx_complete = 1'b0;
        @(negedge clk);
        check("stray_ignored", CW'(dbg_state), CW'(2));
        tick();
        rx_packet(0, 1'b0);
        for (int k = 1; k < 2 * N; k++) load_pkt(k, 1'b0);
        check("load_start_cnt", CW'(st_cnt), CW'(8));
        check("load_op", CW'(st_op_bad), CW'(0));
        exp_op = 1'b1;
        send_results(40);
        check("total_start_cnt", CW'(st_cnt), CW'(12));
        check("tx_op", CW'(st_op_bad), CW'(0));
        check("done_cnt_1", CW'(done_cnt), CW'(1));
        check("err_clean_job", CW'(bus.err), CW'(0));

        // Busy gating on the first load, oversized packet at B column 1
        exp_op = 1'b0; st_cnt = 0;
        bus.comm_busy = 1'b1;
        pulse_go();
        cnt = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (bus.comm_start) cnt++;
            tick();
        end
        check("start_while_busy", CW'(cnt), CW'(0));
        bus.comm_busy = 1'b0;
        @(negedge clk);
        check("start_first_free", CW'({bus.comm_start, bus.comm_op}), CW'(2'b10));
        tick();
        rx_packet(0, 1'b0);
        for (int k = 1; k < 2 * N; k++) begin
            load_pkt(k, k == 5);
            if (k == 5) begin
                @(negedge clk);
                check("err_size", CW'(bus.err), CW'(1));
            end
        end
        exp_op = 1'b1;
        send_results(10);
        check("err_sticky", CW'(bus.err), CW'(1));
        check("done_cnt_2", CW'(done_cnt), CW'(2));

        // Timeout in MM_WAIT
        exp_op = 1'b0;
        pulse_go();
        @(negedge clk);
        check("err_cleared_by_go", CW'({bus.err, bus.comm_start}), CW'(2'b01));
        tick();
        rx_packet(0, 1'b0);
        for (int k = 1; k < 2 * N; k++) load_pkt(k, 1'b0);
        wait_for(1, 20, "mm_start");
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (dbg_state == 4'd5) cnt++;
            else break;
        end
        check("timeout_cycles", CW'(cnt), CW'(TIMEOUT));
        check("timeout_state", CW'({dbg_state, bus.busy}), CW'(0));
        check("timeout_err", CW'(bus.err), CW'(1));
        check("timeout_no_done", CW'(done_cnt), CW'(2));
        check("sb_empty", CW'(exp_q.size()), CW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
